// File: rtl/cpu_mem_pkg.sv
// Shared encodings for the host memory-access responder: opcodes, targets,
// controller states, sw_mem_cmd field ranges and hw_status bit positions.
package cpu_mem_pkg;

  typedef enum logic [1:0] {
    OP_NOP   = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic {
    TGT_IMEM = 1'b0,
    TGT_DMEM = 1'b1
  } target_e;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ISSUE   = 2'b01,
    WAIT_RD = 2'b10
  } state_e;

  localparam int CMD_OP_LSB  = 0;
  localparam int CMD_OP_MSB  = 1;
  localparam int CMD_TGT_BIT = 2;
  localparam int CMD_TAG_LSB = 8;
  localparam int CMD_TAG_MSB = 15;

  localparam int STAT_BUSY_BIT        = 8;
  localparam int STAT_ERR_RUNNING_BIT = 9;
  localparam int STAT_ERR_ALIGN_BIT   = 10;
  localparam int STAT_ERR_TIMEOUT_BIT = 11;
  localparam int STAT_ERR_OP_BIT      = 12;

  typedef struct packed {
    logic err_op;
    logic err_timeout;
    logic err_align;
    logic err_running;
  } err_t;

  function automatic logic [31:0] pack_status(input logic [7:0] tag, input logic busy,
                                              input err_t errs);
    logic [31:0] s;
    s                       = '0;
    s[7:0]                  = tag;
    s[STAT_BUSY_BIT]        = busy;
    s[STAT_ERR_RUNNING_BIT] = errs.err_running;
    s[STAT_ERR_ALIGN_BIT]   = errs.err_align;
    s[STAT_ERR_TIMEOUT_BIT] = errs.err_timeout;
    s[STAT_ERR_OP_BIT]      = errs.err_op;
    return s;
  endfunction

endpackage

// File: rtl/cpu_mem_cmd_ctrl_timeout.sv
// Access watchdog: cleared by load, counts busy cycles, flags expire on the
// LIMIT-th counted cycle. Only instantiated when CPU_MEM_TIMEOUT_EN is defined.
module cpu_mem_timeout #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic count,
  output logic expire
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;
  logic          at_limit;

  // Saturates so a read granted on the final cycle still expires in WAIT_RD.
  assign at_limit = (cnt >= CW'(LIMIT - 1));
  assign expire   = count && at_limit;

  always_ff @(posedge clk) begin
    if (reset || load) begin
      cnt <= '0;
    end else if (count && !at_limit) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_mem_cmd_ctrl.sv
// Host-register driven memory access responder for the CPU block.
// Optional access timeout is compiled in with `define CPU_MEM_TIMEOUT_EN.
module cpu_mem_cmd_ctrl
  import cpu_mem_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 9,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               sw_reset,
  input  logic [31:0]               sw_mem_addr,
  input  logic [31:0]               sw_mem_wdata,
  input  logic [31:0]               sw_mem_cmd,
  output logic                      cpu_hold,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic                      mem_sel,
  output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic                      mem_gnt,
  input  logic                      mem_rvalid,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic [31:0]               hw_mem_rdata,
  output logic [31:0]               hw_status
);

  state_e                    state, state_next;
  logic [7:0]                last_tag, done_tag, cmd_tag;
  op_e                       cmd_op, op_q;
  target_e                   sel_q;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [31:0]               rdata_q;
  err_t                      errs, cmd_errs;
  logic                      busy, new_cmd, start, gnt_hit, rd_done, timeout_hit, abort;
  logic                      unused_bits;

  assign unused_bits = &{1'b0, sw_reset[31:1], sw_mem_addr[31:MEM_ADDR_WIDTH+2],
                         sw_mem_cmd[31:16], sw_mem_cmd[7:3]};

  assign cmd_tag = sw_mem_cmd[CMD_TAG_MSB:CMD_TAG_LSB];
  assign cmd_op  = op_e'(sw_mem_cmd[CMD_OP_MSB:CMD_OP_LSB]);
  assign new_cmd = (state == IDLE) && (cmd_tag != last_tag);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    cmd_errs = '0;
    if (!sw_reset[0]) begin
      cmd_errs.err_running = 1'b1;
    end else if (cmd_op == OP_RSVD) begin
      cmd_errs.err_op = 1'b1;
    end else if (cmd_op != OP_NOP && sw_mem_addr[1:0] != 2'b00) begin
      cmd_errs.err_align = 1'b1;
    end
  end

  assign start   = new_cmd && (cmd_errs == '0) && (cmd_op != OP_NOP);
  assign gnt_hit = (state == ISSUE) && mem_gnt;
  assign rd_done = (state == WAIT_RD) && mem_rvalid;
  // A handshake landing on the expiry cycle wins over the timeout.
  assign abort   = timeout_hit && !gnt_hit && !rd_done;

`ifdef CPU_MEM_TIMEOUT_EN
  cpu_mem_timeout #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .load  (start),
    .count (busy),
    .expire(timeout_hit)
  );
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = ISSUE;
      ISSUE: begin
        if (gnt_hit)    state_next = (op_q == OP_WRITE) ? IDLE : WAIT_RD;
        else if (abort) state_next = IDLE;
      end
      WAIT_RD: if (rd_done || abort) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy     = (state != IDLE);
    mem_req  = (state == ISSUE);
    cpu_hold = sw_reset[0] | busy;
  end

  // NOTE: latched command fields are reset too, so every output reads 0 after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_tag <= '0;
      done_tag <= '0;
      errs     <= '0;
      op_q     <= OP_NOP;
      sel_q    <= TGT_IMEM;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      if (new_cmd) begin
        last_tag <= cmd_tag;
        errs     <= cmd_errs;
        if (!start) done_tag <= cmd_tag;
      end
      if (start) begin
        op_q    <= cmd_op;
        sel_q   <= target_e'(sw_mem_cmd[CMD_TGT_BIT]);
        addr_q  <= sw_mem_addr[MEM_ADDR_WIDTH+1:2];
        wdata_q <= sw_mem_wdata[DATA_WIDTH-1:0];
      end
      if (gnt_hit && op_q == OP_WRITE) done_tag <= last_tag;
      if (rd_done) begin
        rdata_q  <= 32'(mem_rdata);
        done_tag <= last_tag;
      end
      if (abort) begin
        errs.err_timeout <= 1'b1;
        done_tag         <= last_tag;
      end
    end
  end

  assign mem_we       = (op_q == OP_WRITE);
  assign mem_sel      = (sel_q == TGT_DMEM);
  assign mem_addr     = addr_q;
  assign mem_wdata    = wdata_q;
  assign hw_mem_rdata = rdata_q;
  assign hw_status    = pack_status(done_tag, busy, errs);

endmodule

// File: tb/tb_cpu_mem_cmd_ctrl.sv
// Self-checking bench for cpu_mem_cmd_ctrl: transaction-level model plus
// directed host commands; timeout scenario runs when CPU_MEM_TIMEOUT_EN is defined.
module tb_cpu_mem_cmd_ctrl;

  localparam int AW = 9;
  localparam int DW = 32;
`ifdef CPU_MEM_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 255;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   sw_reset = '0, sw_mem_addr = '0, sw_mem_wdata = '0, sw_mem_cmd = '0;
  logic          cpu_hold, mem_req, mem_we, mem_sel;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic [31:0]   hw_mem_rdata, hw_status;

  int n_vec = 0;
  int n_bad = 0;

  cpu_mem_cmd_ctrl #(
    .MEM_ADDR_WIDTH(AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .sw_reset    (sw_reset),
    .sw_mem_addr (sw_mem_addr),
    .sw_mem_wdata(sw_mem_wdata),
    .sw_mem_cmd  (sw_mem_cmd),
    .cpu_hold    (cpu_hold),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_sel     (mem_sel),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_gnt     (mem_gnt),
    .mem_rvalid  (mem_rvalid),
    .mem_rdata   (mem_rdata),
    .hw_mem_rdata(hw_mem_rdata),
    .hw_status   (hw_status)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory responder: grants after gnt_delay request cycles, returns read
  // data rv_delay cycles after the grant.
  int            gnt_delay = 0, rv_delay = 1, gnt_cnt = 0, rv_cnt = 0;
  int            req_cycles = 0, hs_count = 0;
  bit            gnt_never = 1'b0, rd_pending = 1'b0;
  logic [31:0]   rdata_next = '0;
  logic [AW-1:0] last_hs_addr = '0;

  always @(negedge clk) begin
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b0;
    if (rd_pending) begin
      if (rv_cnt >= rv_delay) begin
        mem_rvalid = 1'b1;
        mem_rdata  = rdata_next;
        rd_pending = 1'b0;
      end else begin
        rv_cnt++;
      end
    end else if (mem_req) begin
      req_cycles++;
      if (!gnt_never && gnt_cnt >= gnt_delay) begin
        mem_gnt      = 1'b1;
        gnt_cnt      = 0;
        hs_count++;
        last_hs_addr = mem_addr;
        if (!mem_we) begin
          rd_pending = 1'b1;
          rv_cnt     = 1;
        end
      end else begin
        gnt_cnt++;
      end
    end else begin
      gnt_cnt = 0;
    end
  end

  // Transaction-level model of the host protocol.
  bit            m_busy = 0, m_granted = 0, m_we = 0, m_sel = 0;
  bit            e_run = 0, e_align = 0, e_to = 0, e_op = 0;
  logic [7:0]    m_last = '0, m_done = '0;
  logic [31:0]   m_rdata = '0, m_wdata = '0;
  logic [AW-1:0] m_addr = '0;
  int            m_age = 0;

  always @(posedge clk) begin
    logic [7:0] tag;
    logic [1:0] op;
    bit         fin, gnt_now, to_now;
    if (reset) begin
      m_busy = 0; m_granted = 0; m_we = 0; m_sel = 0;
      e_run = 0; e_align = 0; e_to = 0; e_op = 0;
      m_last = '0; m_done = '0; m_rdata = '0; m_wdata = '0; m_addr = '0;
    end else if (!m_busy) begin
      tag = sw_mem_cmd[15:8];
      op  = sw_mem_cmd[1:0];
      if (tag != m_last) begin
        m_last  = tag;
        e_run   = (sw_reset[0] == 1'b0);
        e_op    = !e_run && op == 2'd3;
        e_align = !e_run && !e_op && op != 2'd0 && sw_mem_addr[1:0] != 2'd0;
        e_to    = 0;
        if (e_run || e_op || e_align || op == 2'd0) begin
          m_done = tag;
        end else begin
          m_busy = 1; m_granted = 0; m_age = 0;
          m_we = (op == 2'd1); m_sel = sw_mem_cmd[2];
          m_addr = sw_mem_addr[AW+1:2]; m_wdata = sw_mem_wdata;
        end
      end
    end else begin
      fin = 0; gnt_now = 0;
`ifdef CPU_MEM_TIMEOUT_EN
      to_now = (m_age >= TO - 1);
`else
      to_now = 0;
`endif
      if (!m_granted && mem_gnt) begin
        gnt_now = 1;
        if (m_we) fin = 1; else m_granted = 1;
      end else if (m_granted && mem_rvalid) begin
        m_rdata = mem_rdata;
        fin = 1;
      end
      if (!fin && !gnt_now && to_now) begin
        e_to = 1;
        fin  = 1;
      end
      m_age++;
      if (fin) begin
        m_busy = 0; m_granted = 0; m_done = m_last;
      end
    end
  end

  always @(posedge clk) begin
    logic [31:0] exp_status;
    bit          exp_req;
    #1;
    exp_status = {19'b0, e_op, e_to, e_align, e_run, m_busy, m_done};
    exp_req    = m_busy && !m_granted;
    check("hw_status", hw_status, exp_status);
    check("hw_mem_rdata", hw_mem_rdata, m_rdata);
    check("mem_req", 32'(mem_req), 32'(exp_req));
    check("cpu_hold", 32'(cpu_hold), 32'(sw_reset[0] | m_busy));
    if (exp_req) begin
      check("mem_addr", 32'(mem_addr), 32'(m_addr));
      check("mem_we", 32'(mem_we), 32'(m_we));
      check("mem_sel", 32'(mem_sel), 32'(m_sel));
      check("mem_wdata", 32'(mem_wdata), m_wdata);
    end
  end

  task automatic drive_slot();
    @(negedge clk);
    #1;
  endtask

  task automatic sample_slot();
    @(posedge clk);
    #2;
  endtask

  task automatic host_cmd(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [7:0] tag, input logic tgt, input logic [1:0] op);
    drive_slot();
    sw_mem_addr  = addr;
    sw_mem_wdata = wdata;
    sw_mem_cmd   = {16'h0, tag, 5'b0, tgt, op};
  endtask

  task automatic wait_done(input logic [7:0] tag);
    int k;
    k = 0;
    do begin
      sample_slot();
      k++;
    end while (!(hw_status[7:0] == tag && !hw_status[8]) && k < 200);
    if (k >= 200) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_done tag 0x%02h: no completion within 200 cycles", tag);
    end
  endtask

  task automatic check_all_zero(input string tag_name);
    check({tag_name, ".mem_req"},      32'(mem_req), 32'h0);
    check({tag_name, ".mem_we"},       32'(mem_we), 32'h0);
    check({tag_name, ".mem_sel"},      32'(mem_sel), 32'h0);
    check({tag_name, ".mem_addr"},     32'(mem_addr), 32'h0);
    check({tag_name, ".mem_wdata"},    32'(mem_wdata), 32'h0);
    check({tag_name, ".hw_status"},    hw_status, 32'h0);
    check({tag_name, ".hw_mem_rdata"}, hw_mem_rdata, 32'h0);
    check({tag_name, ".cpu_hold"},     32'(cpu_hold), 32'h0);
  endtask

  initial begin
    int req0, hs0;

    // Reset state
    repeat (2) sample_slot();
    check_all_zero("reset");
    drive_slot();
    reset    = 1'b0;
    sw_reset = 32'h1;

    // Write imem, immediate grant
    req0 = req_cycles;
    host_cmd(32'h10, 32'hCAFEF00D, 8'h01, 1'b0, 2'b01);
    sample_slot();
    check("wr.req", 32'(mem_req), 32'h1);
    check("wr.addr", 32'(mem_addr), 32'h4);
    check("wr.we", 32'(mem_we), 32'h1);
    check("wr.wdata", 32'(mem_wdata), 32'hCAFEF00D);
    check("wr.busy_status", hw_status, 32'h0000_0100);
    sample_slot();
    check("wr.done_status", hw_status, 32'h0000_0001);
    check("wr.req_cycles", 32'(req_cycles - req0), 32'h1);

    // Read dmem, grant immediate, rvalid two cycles after grant
    gnt_delay  = 0;
    rv_delay   = 2;
    rdata_next = 32'h12345678;
    host_cmd(32'h20, 32'h0, 8'h02, 1'b1, 2'b10);
    sample_slot();
    check("rd.addr", 32'(mem_addr), 32'h8);
    check("rd.sel", 32'(mem_sel), 32'h1);
    check("rd.we", 32'(mem_we), 32'h0);
    repeat (2) sample_slot();
    check("rd.wait_status", hw_status, 32'h0000_0101);
    sample_slot();
    check("rd.rdata", hw_mem_rdata, 32'h12345678);
    check("rd.done_status", hw_status, 32'h0000_0002);

    // Core running -> err_running, then a good command clears it
    req0 = req_cycles;
    drive_slot();
    sw_reset = 32'h0;
    host_cmd(32'h10, 32'h1111_1111, 8'h03, 1'b0, 2'b01);
    sample_slot();
    check("run.status", hw_status, 32'h0000_0203);
    drive_slot();
    sw_reset = 32'h1;
    host_cmd(32'h0C, 32'h2222_2222, 8'h06, 1'b1, 2'b01);
    wait_done(8'h06);
    check("run.cleared", hw_status, 32'h0000_0006);

    // Misaligned address, reserved opcode
    req0 = req_cycles;
    host_cmd(32'h22, 32'h3333_3333, 8'h04, 1'b0, 2'b01);
    sample_slot();
    check("align.status", hw_status, 32'h0000_0404);
    host_cmd(32'h0, 32'h0, 8'h05, 1'b0, 2'b11);
    sample_slot();
    check("op.status", hw_status, 32'h0000_1005);
    check("err.no_req", 32'(req_cycles - req0), 32'h0);

    // Tag churn during a stalled read; sw_reset dropped mid-access
    hs0        = hs_count;
    gnt_delay  = 10;
    rv_delay   = 1;
    rdata_next = 32'hDEADBEEF;
    host_cmd(32'h40, 32'h0, 8'h07, 1'b0, 2'b10);
    repeat (2) sample_slot();
    host_cmd(32'h44, 32'h4444_4444, 8'h08, 1'b0, 2'b01);
    sw_reset = 32'h0;
    sample_slot();
    check("churn.hold", 32'(cpu_hold), 32'h1);
    repeat (2) sample_slot();
    host_cmd(32'h48, 32'hA5A5_A5A5, 8'h09, 1'b1, 2'b01);
    sw_reset = 32'h1;
    wait_done(8'h09);
    check("churn.handshakes", 32'(hs_count - hs0), 32'h2);
    check("churn.last_addr", 32'(last_hs_addr), 32'h12);
    check("churn.rdata", hw_mem_rdata, 32'hDEADBEEF);
    check("churn.status", hw_status, 32'h0000_0009);
    gnt_delay = 0;

    // Reset while a write is stuck in ISSUE
    gnt_never = 1'b1;
    host_cmd(32'h30, 32'h5555_5555, 8'h0A, 1'b1, 2'b01);
    repeat (3) sample_slot();
    check("rst.req_before", 32'(mem_req), 32'h1);
    drive_slot();
    reset      = 1'b1;
    sw_reset   = 32'h0;
    sw_mem_cmd = 32'h0;
    sample_slot();
    check_all_zero("midrst");
    drive_slot();
    reset     = 1'b0;
    gnt_never = 1'b0;
    sw_reset  = 32'h1;

`ifdef CPU_MEM_TIMEOUT_EN
    // Grant never arrives -> timeout after TO request cycles
    gnt_never = 1'b1;
    req0      = req_cycles;
    host_cmd(32'h50, 32'h6666_6666, 8'h0B, 1'b0, 2'b01);
    wait_done(8'h0B);
    check("to.status", hw_status, 32'h0000_080B);
    check("to.req_cycles", 32'(req_cycles - req0), 32'(TO));
    check("to.rdata_kept", hw_mem_rdata, 32'h0);
    gnt_never = 1'b0;
`endif

    repeat (3) sample_slot();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
